// File: rtl/ir_cmd_scheduler.sv
// NEC IR command scheduler: frame validation, address filtering, key-hold tracking,
// rate-divided auto-repeat and a first-word fall-through command FIFO.
module ir_cmd_scheduler #(
  parameter logic [7:0]  DEV_ADDR     = 8'h00,
  parameter bit          ADDR_FILTER  = 1'b1,
  parameter int unsigned HOLD_TIMEOUT = 5940000,
  parameter int unsigned REPEAT_DIV   = 3,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  input  logic        FRAME_VALID,
  input  logic [31:0] FRAME_DATA,
  input  logic        REPEAT_VALID,
  output logic        CMD_VALID,
  input  logic        CMD_READY,
  output logic [7:0]  CMD_DATA,
  output logic        CMD_IS_REPEAT,
  output logic        HELD,
  output logic        OVERFLOW,
  output logic [7:0]  ERR_COUNT,
  output logic [4:0]  FIFO_LEVEL,
  input  logic        CLR_FLAGS
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [23:0] TIMER_LOAD = 24'(HOLD_TIMEOUT);
  localparam logic [3:0]  RPT_LAST   = 4'(REPEAT_DIV);
  localparam logic [4:0]  DEPTH      = 5'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_HELD} state_t;

  state_t      state, state_nxt;
  logic [23:0] timer, timer_nxt;
  logic [3:0]  rpt_cnt, rpt_nxt, rpt_inc;
  logic [7:0]  last_cmd, last_nxt;
  logic        push;
  logic [8:0]  push_data;

  logic [7:0] f_addr, f_cmd;
  logic       frame_ok, frame_err, frame_acc;

  assign f_addr    = FRAME_DATA[7:0];
  assign f_cmd     = FRAME_DATA[23:16];
  assign frame_ok  = (FRAME_DATA[15:8] == ~f_addr) && (FRAME_DATA[31:24] == ~f_cmd);
  assign frame_err = FRAME_VALID && !frame_ok;
  assign frame_acc = FRAME_VALID && frame_ok && (!ADDR_FILTER || (f_addr == DEV_ADDR));
  assign rpt_inc   = rpt_cnt + 4'd1;

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      timer    <= '0;
      rpt_cnt  <= '0;
      last_cmd <= '0;
    end else begin
      state    <= state_nxt;
      timer    <= timer_nxt;
      rpt_cnt  <= rpt_nxt;
      last_cmd <= last_nxt;
    end
  end

  // A frame on the same cycle as a repeat strobe always suppresses the repeat.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    rpt_nxt   = rpt_cnt;
    last_nxt  = last_cmd;
    push      = 1'b0;
    push_data = '0;
    case (state)
      S_IDLE: begin
        if (frame_acc) begin
          push      = 1'b1;
          push_data = {f_cmd, 1'b0};
          last_nxt  = f_cmd;
          timer_nxt = TIMER_LOAD;
          rpt_nxt   = '0;
          state_nxt = S_HELD;
        end
      end
      S_HELD: begin
        if (frame_acc) begin
          push      = 1'b1;
          push_data = {f_cmd, 1'b0};
          last_nxt  = f_cmd;
          timer_nxt = TIMER_LOAD;
          rpt_nxt   = '0;
        end else if (REPEAT_VALID && !FRAME_VALID) begin
          timer_nxt = TIMER_LOAD;
          if (rpt_inc == RPT_LAST) begin
            push      = 1'b1;
            push_data = {last_cmd, 1'b1};
            rpt_nxt   = '0;
          end else begin
            rpt_nxt = rpt_inc;
          end
        end else if (timer <= 24'd1) begin
          timer_nxt = '0;
          rpt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer - 24'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    level;
  logic          pop, full, wr_en, ovf_evt;

  assign pop     = (level != 5'd0) && CMD_READY;
  assign full    = (level == DEPTH);
  assign wr_en   = push && (!full || pop);
  assign ovf_evt = push && full && !pop;

  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointers are exactly log2(depth) wide, so wrap comes for free.
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      OVERFLOW  <= 1'b0;
      ERR_COUNT <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 5'd1;
        2'b01:   level <= level - 5'd1;
        default: level <= level;
      endcase
      if (ovf_evt)        OVERFLOW <= 1'b1;
      else if (CLR_FLAGS) OVERFLOW <= 1'b0;
      if (CLR_FLAGS)                           ERR_COUNT <= frame_err ? 8'd1 : 8'd0;
      else if (frame_err && ERR_COUNT != 8'hFF) ERR_COUNT <= ERR_COUNT + 8'd1;
    end
  end

  assign CMD_VALID     = (level != 5'd0);
  assign CMD_DATA      = CMD_VALID ? mem[rd_ptr][8:1] : 8'd0;
  assign CMD_IS_REPEAT = CMD_VALID ? mem[rd_ptr][0] : 1'b0;
  assign HELD          = (state == S_HELD);
  assign FIFO_LEVEL    = level;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Directed plus randomized bench for ir_cmd_scheduler against a deadline/queue
// based reference model.
module tb_ir_cmd_scheduler;

  localparam int         HT    = 1000;
  localparam int         DIV   = 3;
  localparam int         DEPTH = 4;
  localparam logic [7:0] DEV   = 8'h00;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic        FRAME_VALID = 1'b0;
  logic [31:0] FRAME_DATA = '0;
  logic        REPEAT_VALID = 1'b0;
  logic        CMD_READY = 1'b0;
  logic        CLR_FLAGS = 1'b0;
  logic        CMD_VALID, CMD_IS_REPEAT, HELD, OVERFLOW;
  logic [7:0]  CMD_DATA, ERR_COUNT;
  logic [4:0]  FIFO_LEVEL;

  always #10 CLOCK_50 = ~CLOCK_50;

  ir_cmd_scheduler #(
    .DEV_ADDR(DEV), .ADDR_FILTER(1'b1), .HOLD_TIMEOUT(HT),
    .REPEAT_DIV(DIV), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET),
    .FRAME_VALID(FRAME_VALID), .FRAME_DATA(FRAME_DATA), .REPEAT_VALID(REPEAT_VALID),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DATA(CMD_DATA),
    .CMD_IS_REPEAT(CMD_IS_REPEAT), .HELD(HELD), .OVERFLOW(OVERFLOW),
    .ERR_COUNT(ERR_COUNT), .FIFO_LEVEL(FIFO_LEVEL), .CLR_FLAGS(CLR_FLAGS)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: command queue, held flag with an absolute release deadline.
  logic [8:0] mq[$];
  bit         m_held;
  longint     cyc, rel;
  int         m_rpt, m_err;
  logic [7:0] m_last;
  bit         m_ovf;
  logic [8:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_held = 0; rel = 0; m_rpt = 0; m_last = '0; m_ovf = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit pop, fv, ok, acc, push, ovf_evt, err_evt;
    logic [8:0] pd;
    cyc++;
    pop = CMD_READY && (mq.size() > 0);
    fv  = FRAME_VALID;
    ok  = (FRAME_DATA[15:8] == ~FRAME_DATA[7:0]) && (FRAME_DATA[31:24] == ~FRAME_DATA[23:16]);
    err_evt = fv && !ok;
    acc = fv && ok && (FRAME_DATA[7:0] == DEV);
    push = 0; pd = '0;
    if (acc) begin
      push = 1; pd = {FRAME_DATA[23:16], 1'b0};
      m_last = FRAME_DATA[23:16]; rel = cyc + HT; m_rpt = 0; m_held = 1;
    end else if (m_held && !fv && REPEAT_VALID) begin
      rel = cyc + HT;
      m_rpt++;
      if (m_rpt == DIV) begin
        push = 1; pd = {m_last, 1'b1}; m_rpt = 0;
      end
    end else if (m_held && cyc >= rel) begin
      m_held = 0;
    end
    if (pop) void'(mq.pop_front());
    ovf_evt = 0;
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(pd);
      else ovf_evt = 1;
    end
    if (CLR_FLAGS) m_err = err_evt ? 1 : 0;
    else if (err_evt && m_err < 255) m_err++;
    if (ovf_evt) m_ovf = 1;
    else if (CLR_FLAGS) m_ovf = 0;
  endtask

  task automatic check_model(input string tag);
    logic [8:0] head;
    head = (mq.size() > 0) ? mq[0] : 9'd0;
    chk({tag, "_valid"}, CMD_VALID, (mq.size() > 0));
    chk({tag, "_data"}, CMD_DATA, head[8:1]);
    chk({tag, "_isrpt"}, CMD_IS_REPEAT, head[0]);
    chk({tag, "_held"}, HELD, m_held);
    chk({tag, "_ovf"}, OVERFLOW, m_ovf);
    chk({tag, "_err"}, ERR_COUNT, m_err);
    chk({tag, "_level"}, FIFO_LEVEL, mq.size());
  endtask

  task automatic tick_chk(input string tag);
    model_step();
    @(posedge CLOCK_50);
    #1;
    check_model(tag);
  endtask

  task automatic capture();
    if (CMD_VALID && CMD_READY) got.push_back({CMD_DATA, CMD_IS_REPEAT});
  endtask

  function automatic logic [31:0] frame(input logic [7:0] addr, input logic [7:0] cmd);
    return {~cmd, cmd, ~addr, addr};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] c, a;
    model_reset();
    cyc = 0;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_model("reset");
    chk("reset_level", FIFO_LEVEL, 0);
    RESET = 1'b0;

    // first press, consumer stalled
    FRAME_DATA = 32'hBF40_FF00; FRAME_VALID = 1'b1; CMD_READY = 1'b0;
    tick_chk("t1");
    FRAME_VALID = 1'b0;
    chk("t1_valid_c", CMD_VALID, 1);
    chk("t1_data_c", CMD_DATA, 8'h40);
    chk("t1_isrpt_c", CMD_IS_REPEAT, 0);
    chk("t1_held_c", HELD, 1);
    chk("t1_level_c", FIFO_LEVEL, 1);
    CMD_READY = 1'b1;
    for (int i = 0; i < 1100 && HELD; i++) tick_chk("t1_hold");
    chk("t1_release", HELD, 0);

    // press then six repeats 100 clocks apart
    got.delete();
    FRAME_DATA = 32'hBF40_FF00; FRAME_VALID = 1'b1;
    capture(); tick_chk("t2");
    FRAME_VALID = 1'b0;
    for (int r = 0; r < 6; r++) begin
      repeat (99) begin capture(); tick_chk("t2_gap"); end
      REPEAT_VALID = 1'b1;
      capture(); tick_chk("t2_rpt");
      REPEAT_VALID = 1'b0;
    end
    n = 0;
    while (HELD && n < 1100) begin capture(); tick_chk("t2_tail"); n++; end
    chk("t2_hold_len", n, HT);
    chk("t2_count", got.size(), 3);
    if (got.size() > 0) chk("t2_e0", got[0], 9'h080);
    if (got.size() > 1) chk("t2_e1", got[1], 9'h081);
    if (got.size() > 2) chk("t2_e2", got[2], 9'h081);

    // bad command complement, then clear with a coincident error
    CMD_READY = 1'b0;
    FRAME_DATA = 32'hBE40_FF00; FRAME_VALID = 1'b1;
    repeat (3) tick_chk("t3_bad");
    chk("t3_err3", ERR_COUNT, 3);
    chk("t3_level", FIFO_LEVEL, 0);
    CLR_FLAGS = 1'b1;
    tick_chk("t3_clr");
    CLR_FLAGS = 1'b0; FRAME_VALID = 1'b0;
    chk("t3_err1", ERR_COUNT, 1);

    // foreign address dropped; repeat while idle ignored
    FRAME_DATA = 32'hBF40_FE01; FRAME_VALID = 1'b1;
    tick_chk("t4_addr");
    FRAME_VALID = 1'b0;
    chk("t4_err", ERR_COUNT, 1);
    chk("t4_held", HELD, 0);
    REPEAT_VALID = 1'b1;
    tick_chk("t4_rpt");
    REPEAT_VALID = 1'b0;
    chk("t4_level", FIFO_LEVEL, 0);

    // overflow, ordered drain, push+pop while full
    for (int k = 0; k < 5; k++) begin
      FRAME_DATA = frame(8'h00, 8'(8'h10 + k)); FRAME_VALID = 1'b1;
      tick_chk("t5_fill");
    end
    FRAME_VALID = 1'b0;
    chk("t5_level4", FIFO_LEVEL, 4);
    chk("t5_ovf", OVERFLOW, 1);
    CMD_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t5_drain", CMD_DATA, 8'h10 + k);
      tick_chk("t5_pop");
    end
    chk("t5_empty", FIFO_LEVEL, 0);
    CMD_READY = 1'b0; CLR_FLAGS = 1'b1;
    tick_chk("t5_clr");
    CLR_FLAGS = 1'b0;
    chk("t5_ovf_clr", OVERFLOW, 0);
    for (int k = 0; k < 4; k++) begin
      FRAME_DATA = frame(8'h00, 8'(8'h20 + k)); FRAME_VALID = 1'b1;
      tick_chk("t5_refill");
    end
    FRAME_DATA = frame(8'h00, 8'h24); CMD_READY = 1'b1;
    tick_chk("t5_pushpop");
    FRAME_VALID = 1'b0;
    chk("t5_pp_level", FIFO_LEVEL, 4);
    chk("t5_pp_ovf", OVERFLOW, 0);
    chk("t5_pp_head", CMD_DATA, 8'h21);
    for (int k = 0; k < 6; k++) tick_chk("t5_flush");

    // randomized traffic in busy and quiet phases
    for (int i = 0; i < 4000; i++) begin
      bit busy;
      busy = ((i / 1000) % 2) == 0;
      FRAME_VALID  = busy ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 1499) == 0);
      REPEAT_VALID = busy ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 1999) == 0);
      CMD_READY    = ((i % 800) < 400) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      CLR_FLAGS    = ($urandom_range(0, 299) == 0);
      c = 8'($urandom);
      a = 8'($urandom_range(1, 255));
      case ($urandom_range(0, 3))
        0, 1:    FRAME_DATA = frame(DEV, c);
        2:       FRAME_DATA = frame(a, c);
        default: FRAME_DATA = $urandom;
      endcase
      tick_chk("rnd");
    end
    FRAME_VALID = 1'b0; REPEAT_VALID = 1'b0; CLR_FLAGS = 1'b0; CMD_READY = 1'b1;
    repeat (6) tick_chk("rnd_flush");

    // reset while held with three queued commands
    CMD_READY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      FRAME_DATA = frame(8'h00, 8'(8'h30 + k)); FRAME_VALID = 1'b1;
      tick_chk("t6_fill");
    end
    FRAME_VALID = 1'b0;
    chk("t6_level3", FIFO_LEVEL, 3);
    chk("t6_held1", HELD, 1);
    RESET = 1'b1;
    #1;
    model_reset();
    chk("t6_async_valid", CMD_VALID, 0);
    chk("t6_async_level", FIFO_LEVEL, 0);
    chk("t6_async_held", HELD, 0);
    chk("t6_async_data", CMD_DATA, 0);
    check_model("t6_async");
    @(posedge CLOCK_50);
    #1;
    RESET = 1'b0;
    REPEAT_VALID = 1'b1;
    tick_chk("t6_rpt");
    REPEAT_VALID = 1'b0;
    chk("t6_rpt_level", FIFO_LEVEL, 0);
    chk("t6_rpt_held", HELD, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
